std_8b10b_encode: RTL and testbench
===================================

Name: std_8b10b_encode

Overview:
- Registered 8b/10b transmit encoder and the transmit-side counterpart of std_8b10b_decode.
- Converts byte/K-flag words into 10-bit code groups, tracks running disparity (RD), selects alternate D.x.A7 encodings and optionally inserts K28.5 idles.
- Sits between the link-layer framer and the SERDES/serializer.
- Its output bit order and code tables match std_8b10b_decode exactly, so the two blocks loop back directly.

Parameters:
- IDLE_INSERT, 1: 1 = emit K28.5 whenever the output is free and no input word is presented; 0 = tx_valid drops when no input.
- RD_INIT, 0: running disparity after reset (0 = RD-, 1 = RD+).

Ports:
- clk  in  1  clock.
- nreset  in  1  reset. One clock; reset is synchronous and active-low.
- in_valid  in  1  input word valid.
- in_ready  out  1  input accepted this cycle when in_valid & in_ready.
- K_in  in  1  1 = control character, 0 = data.
- data_in  in  8  byte HGFEDCBA; x = [4:0], y = [7:5].
- tx_valid  out  1  tx_code_group holds a code group.
- tx_ready  in  1  downstream accepts tx_code_group this cycle.
- tx_code_group  out  10  code group; bit 9..0 = a,b,c,d,e,i,f,g,h,j. [9:4] is the 6b sub-block, [3:0] is the 4b sub-block.
- code_err  out  1  qualifies the current tx_code_group: K_in was set with an invalid K value.
- rd_out  out  1  running disparity after the current tx_code_group.

Behaviour:
- Reset (nreset low at a clk edge), outputs take these values on that edge:
  - tx_valid = 0, tx_code_group = 10'h0FA (K28.5 RD-), code_err = 0, rd_out = RD_INIT.
  - Internal RD = RD_INIT.
  - Any pipeline content is discarded. Reset applied mid-stream behaves identically.
- Handshake and latency:
  - One output register stage. in_ready = ~tx_valid | tx_ready (combinational).
  - A word accepted at edge N appears on tx_code_group after edge N, i.e. 1-cycle latency.
  - While tx_valid & ~tx_ready, tx_code_group, code_err and rd_out hold stable and RD does not advance.
- Idle insertion:
  - Applies when IDLE_INSERT = 1, the output register is loadable and in_valid = 0.
  - The register loads K28.5 for the current RD: RD- gives 0x0FA, RD+ gives 0x305. code_err = 0.
  - After the first post-reset edge, tx_valid stays 1 permanently.
  - With IDLE_INSERT = 0, tx_valid clears when the register is unloaded and no new input arrives.
- Encoding:
  - Standard 5b/6b and 3b/4b tables (IEEE 802.3 Clause 36).
  - The 6b sub-block is chosen by the current RD. The 4b sub-block is chosen by the RD after the 6b sub-block.
  - Sub-block RD rule: a disparity ±2 sub-block flips RD. A neutral sub-block keeps RD, including the 000111/111000 and 0011/1100 RD-dependent forms.
  - The new RD is registered together with the code group.
- Alternate A7 (0111/1000) replaces P7 for D.x.7 when either condition holds:
  - RD after 6b is - and x ∈ {17, 18, 20};
  - RD after 6b is + and x ∈ {11, 13, 14}.
- K characters:
  - Valid set: K28.0–K28.7 (0x1C, 0x3C, 0x5C, 0x7C, 0x9C, 0xBC, 0xDC, 0xFC) and K23.7, K27.7, K29.7, K30.7 (0xF7, 0xFB, 0xFD, 0xFE).
  - K28.y uses the 6b form 001111/110000. K.x.7 always uses A7.
  - K_in = 1 with any other value: the byte is encoded as data, code_err = 1 for that group, and RD is updated normally.
- Simultaneous events: when in_valid = 1 and an idle is due in the same cycle, the input word wins. Reset wins over everything.

Test Plan:
1. After reset with RD_INIT = 0, send D.0.0 (K_in = 0, 0x00) -> 1 cycle later tx_code_group = 0x274, rd_out = 0. Then send D.21.5 (0xB5) -> 0x2AA, rd_out = 0.
2. From RD-, send K28.5 (K_in = 1, 0xBC) twice -> 0x0FA with rd_out = 1, then 0x305 with rd_out = 0.
3. From RD-, send D.17.7 (0xF1) -> 0x237 (A7 selected), rd_out = 1. Then D.11.7 (0xEB) from RD+ -> 6b 110100, A7 1000, i.e. 0x348, rd_out = 0.
4. Hold tx_ready = 0 for 5 cycles with in_valid = 1 -> in_ready = 0, tx_code_group/rd_out stable, no word lost. Release -> words emerge in order.
5. IDLE_INSERT = 1, in_valid = 0 for 4 cycles -> 0x0FA, 0x305, 0x0FA, 0x305. Assert nreset = 0 mid-stream -> next edge tx_valid = 0, tx_code_group = 0x0FA, rd_out = 0.
6. K_in = 1, data 0x00 -> tx_code_group = 0x274, code_err = 1 for that one group. Loop all 256 D and 12 K codes through std_8b10b_decode -> bytes/K match, no code or disparity errors.

Source files
------------

// File: rtl/std_8b10b_encode_if.sv
// Byte-side and line-side handshake bundle of the 8b/10b encoder.
// slave = encoder view, master = link/serializer view.
interface std_8b10b_encode_if;
  logic       in_valid;
  logic       in_ready;
  logic       K_in;
  logic [7:0] data_in;
  logic       tx_valid;
  logic       tx_ready;
  logic [9:0] tx_code_group;
  logic       code_err;
  logic       rd_out;

  modport slave (
    input  in_valid,
    input  K_in,
    input  data_in,
    input  tx_ready,
    output in_ready,
    output tx_valid,
    output tx_code_group,
    output code_err,
    output rd_out
  );

  modport master (
    output in_valid,
    output K_in,
    output data_in,
    output tx_ready,
    input  in_ready,
    input  tx_valid,
    input  tx_code_group,
    input  code_err,
    input  rd_out
  );
endinterface

// File: rtl/std_8b10b_encode.sv
// Registered 8b/10b transmit encoder with running disparity,
// alternate D.x.A7 selection and optional K28.5 idle fill.
module std_8b10b_encode #(
  parameter bit IDLE_INSERT = 1'b1,
  parameter bit RD_INIT     = 1'b0
) (
  input logic              clk,
  input logic              nreset,
  std_8b10b_encode_if.slave bus
);

  localparam logic [9:0] K285_NEG = 10'h0FA;
  localparam logic [9:0] K285_POS = 10'h305;

  // 5b/6b table, RD- column (abcdei)
  function automatic logic [5:0] t6(input logic [4:0] x);
    logic [5:0] r;
    case (x)
      5'd0:    r = 6'b100111;
      5'd1:    r = 6'b011101;
      5'd2:    r = 6'b101101;
      5'd3:    r = 6'b110001;
      5'd4:    r = 6'b110101;
      5'd5:    r = 6'b101001;
      5'd6:    r = 6'b011001;
      5'd7:    r = 6'b111000;
      5'd8:    r = 6'b111001;
      5'd9:    r = 6'b100101;
      5'd10:   r = 6'b010101;
      5'd11:   r = 6'b110100;
      5'd12:   r = 6'b001101;
      5'd13:   r = 6'b101100;
      5'd14:   r = 6'b011100;
      5'd15:   r = 6'b010111;
      5'd16:   r = 6'b011011;
      5'd17:   r = 6'b100011;
      5'd18:   r = 6'b010011;
      5'd19:   r = 6'b110010;
      5'd20:   r = 6'b001011;
      5'd21:   r = 6'b101010;
      5'd22:   r = 6'b011010;
      5'd23:   r = 6'b111010;
      5'd24:   r = 6'b110011;
      5'd25:   r = 6'b100110;
      5'd26:   r = 6'b010110;
      5'd27:   r = 6'b110110;
      5'd28:   r = 6'b001110;
      5'd29:   r = 6'b101110;
      5'd30:   r = 6'b011110;
      default: r = 6'b101011;
    endcase
    return r;
  endfunction

  // 3b/4b table, RD- column (fghj), primary P7 for y=7
  function automatic logic [3:0] t4(input logic [2:0] y);
    logic [3:0] r;
    case (y)
      3'd0:    r = 4'b1011;
      3'd1:    r = 4'b1001;
      3'd2:    r = 4'b0101;
      3'd3:    r = 4'b1100;
      3'd4:    r = 4'b1101;
      3'd5:    r = 4'b1010;
      3'd6:    r = 4'b0110;
      default: r = 4'b1110;
    endcase
    return r;
  endfunction

  logic       vld_q, vld_d;
  logic [9:0] code_q, code_d;
  logic       err_q, err_d;
  logic       rd_q, rd_d;

  logic [4:0] x;
  logic [2:0] y;
  logic       k28, k7, kok;
  logic [5:0] s6m, s6;
  logic [3:0] s4m, s4;
  logic       bal6, bal4, flip6, flip4;
  logic       rd6, a7, a7_neg, a7_pos;
  logic       k28_inv;
  logic [9:0] enc_code;
  logic       enc_err, enc_rd;
  logic [9:0] idle_code;
  logic       load;

  assign load          = ~vld_q | bus.tx_ready;
  assign bus.in_ready  = load;
  assign bus.tx_valid  = vld_q;
  assign bus.tx_code_group = code_q;
  assign bus.code_err  = err_q;
  assign bus.rd_out    = rd_q;

  assign idle_code = rd_q ? K285_POS : K285_NEG;

  // Encode the presented word against the current running disparity
  always_comb begin
    x   = bus.data_in[4:0];
    y   = bus.data_in[7:5];
    k28 = bus.K_in & (x == 5'd28);
    k7  = bus.K_in & (y == 3'd7) &
          ((x == 5'd23) | (x == 5'd27) |
           (x == 5'd29) | (x == 5'd30));
    kok = k28 | k7;

    s6m   = k28 ? 6'b001111 : t6(x);
    bal6  = ($countones(s6m) == 3);
    flip6 = ~bal6 | (x == 5'd7);
    s6    = (rd_q & flip6) ? ~s6m : s6m;
    rd6   = bal6 ? rd_q : ~rd_q;

    a7_neg = ~rd6 & ((x == 5'd17) | (x == 5'd18) |
                     (x == 5'd20));
    a7_pos = rd6 & ((x == 5'd11) | (x == 5'd13) |
                    (x == 5'd14));
    a7 = (y == 3'd7) & (kok | a7_neg | a7_pos);

    s4m   = a7 ? 4'b0111 : t4(y);
    bal4  = ($countones(s4m) == 2);
    flip4 = ~bal4 | (y == 3'd3);
    s4    = (rd6 & flip4) ? ~s4m : s4m;

    // K28 keeps comma polarity: neutral 4b forms invert after RD-
    k28_inv = k28 & ~rd6 &
              ((y == 3'd1) | (y == 3'd2) |
               (y == 3'd5) | (y == 3'd6));
    if (k28_inv) s4 = ~s4;

    enc_code = {s6, s4};
    enc_rd   = bal4 ? rd6 : ~rd6;
    enc_err  = bus.K_in & ~kok;
  end

  // Next output register contents: input word beats idle fill
  always_comb begin
    vld_d  = vld_q;
    code_d = code_q;
    err_d  = err_q;
    rd_d   = rd_q;
    if (load) begin
      unique case (1'b1)
        bus.in_valid: begin
          vld_d  = 1'b1;
          code_d = enc_code;
          err_d  = enc_err;
          rd_d   = enc_rd;
        end
        (~bus.in_valid & IDLE_INSERT): begin
          vld_d  = 1'b1;
          code_d = idle_code;
          err_d  = 1'b0;
          rd_d   = ~rd_q;
        end
        default: begin
          vld_d = 1'b0;
        end
      endcase
    end
  end

  // Output register stage with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!nreset) begin
      vld_q  <= 1'b0;
      code_q <= K285_NEG;
      err_q  <= 1'b0;
      rd_q   <= RD_INIT;
    end else begin
      vld_q  <= vld_d;
      code_q <= code_d;
      err_q  <= err_d;
      rd_q   <= rd_d;
    end
  end

endmodule

// File: tb/tb_std_8b10b_encode.sv
// Bench for std_8b10b_encode: directed vectors plus a
// scoreboard fed from a table-based reference encoder.
module tb_std_8b10b_encode;

  typedef struct packed {
    logic [9:0] code;
    logic       err;
    logic       rd;
  } exp_t;

  localparam logic [5:0] T6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001,
    6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100,
    6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010,
    6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110,
    6'b001110, 6'b101110, 6'b011110, 6'b101011
  };
  localparam logic [3:0] T4 [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100,
    4'b1101, 4'b1010, 4'b0110, 4'b1110
  };
  localparam logic [7:0] KB [12] = '{
    8'h1C, 8'h3C, 8'h5C, 8'h7C, 8'h9C, 8'hBC,
    8'hDC, 8'hFC, 8'hF7, 8'hFB, 8'hFD, 8'hFE
  };
  // full K code groups for RD-; RD+ is the complement
  localparam logic [9:0] KC [12] = '{
    10'h0F4, 10'h0F9, 10'h0F5, 10'h0F3, 10'h0F2, 10'h0FA,
    10'h0F6, 10'h0F8, 10'h3A8, 10'h368, 10'h2E8, 10'h1E8
  };

  logic clk;
  logic nreset;
  std_8b10b_encode_if bus();

  std_8b10b_encode dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  int   n_chk;
  int   n_fail;
  exp_t sbq[$];
  bit   mrd;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model(input bit k, input logic [7:0] d,
                       input bit rd, output logic [9:0] c,
                       output bit e, output bit rn);
    logic [5:0] s6;
    logic [3:0] s4;
    logic [4:0] x;
    logic [2:0] y;
    bit r6, alt, hit;
    hit = 1'b0;
    c = '0;
    for (int i = 0; i < 12; i++) begin
      if (k && d == KB[i]) begin
        hit = 1'b1;
        c = rd ? ~KC[i] : KC[i];
      end
    end
    if (hit) begin
      e  = 1'b0;
      rn = ($countones(c) == 5) ? rd : ~rd;
    end else begin
      x  = d[4:0];
      y  = d[7:5];
      s6 = T6[x];
      if (rd && ($countones(s6) != 3 || x == 5'd7))
        s6 = ~s6;
      r6 = ($countones(s6) == 3) ? rd : ~rd;
      alt = (y == 3'd7) &&
            ((!r6 && (x == 17 || x == 18 || x == 20)) ||
             (r6 && (x == 11 || x == 13 || x == 14)));
      s4 = alt ? 4'b0111 : T4[y];
      if (r6 && ($countones(s4) != 2 || y == 3'd3))
        s4 = ~s4;
      rn = ($countones(s4) == 2) ? r6 : ~r6;
      c  = {s6, s4};
      e  = k;
    end
  endtask

  // one clock: drive at negedge, score the visible group, push
  task automatic cyc(input bit v, input bit k,
                     input logic [7:0] d, input bit rdy,
                     output bit acc);
    exp_t       e;
    logic [9:0] c;
    bit         er, rn;
    bus.in_valid = v;
    bus.K_in     = k;
    bus.data_in  = d;
    bus.tx_ready = rdy;
    #1;
    if (bus.tx_valid) begin
      n_chk++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL sb_empty: got %h want none",
                 bus.tx_code_group);
      end else begin
        e = sbq[0];
        if ({bus.tx_code_group, bus.code_err, bus.rd_out}
            !== {e.code, e.err, e.rd}) begin
          n_fail++;
          $display("FAIL sb_group: got %h/%b/%b want %h/%b/%b",
                   bus.tx_code_group, bus.code_err, bus.rd_out,
                   e.code, e.err, e.rd);
        end
        if (rdy) void'(sbq.pop_front());
      end
    end else if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_stale: got tx_valid 0 want 1");
    end
    acc = bus.in_ready;
    n_chk++;
    if (bus.in_ready !== (!bus.tx_valid || rdy)) begin
      n_fail++;
      $display("FAIL in_ready: got %b want %b",
               bus.in_ready, (!bus.tx_valid || rdy));
    end
    if (acc) begin
      if (v) begin
        model(k, d, mrd, c, er, rn);
      end else begin
        c  = mrd ? 10'h305 : 10'h0FA;
        er = 1'b0;
        rn = ~mrd;
      end
      e.code = c;
      e.err  = er;
      e.rd   = rn;
      sbq.push_back(e);
      mrd = rn;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    nreset = 1'b0;
    bus.in_valid = 1'b1;
    bus.K_in = 1'b0;
    bus.data_in = 8'h55;
    bus.tx_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sbq.delete();
    mrd = 1'b0;
    nreset = 1'b1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    bus.in_valid = 1'b1;
    bus.tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk += 5;
    if (bus.tx_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_valid: got %b want 0", bus.tx_valid);
    end
    if (bus.tx_code_group !== 10'h0FA) begin
      n_fail++;
      $display("FAIL rst_code: got %h want 0fa",
               bus.tx_code_group);
    end
    if (bus.code_err !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_err: got %b want 0", bus.code_err);
    end
    if (bus.rd_out !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_rd: got %b want 0", bus.rd_out);
    end
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready: got %b want 1", bus.in_ready);
    end
    sbq.delete();
    mrd = 1'b0;
    nreset = 1'b1;
  endtask

  task automatic test_data();
    bit acc;
    do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b1, acc);
    n_chk++;
    if ({bus.tx_code_group, bus.rd_out} !== {10'h274, 1'b0}) begin
      n_fail++;
      $display("FAIL d0_0: got %h/%b want 274/0",
               bus.tx_code_group, bus.rd_out);
    end
    cyc(1'b1, 1'b0, 8'hB5, 1'b1, acc);
    n_chk++;
    if ({bus.tx_code_group, bus.rd_out} !== {10'h2AA, 1'b0}) begin
      n_fail++;
      $display("FAIL d21_5: got %h/%b want 2aa/0",
               bus.tx_code_group, bus.rd_out);
    end
  endtask

  task automatic test_k285();
    bit acc;
    cyc(1'b1, 1'b1, 8'hBC, 1'b1, acc);
    n_chk++;
    if ({bus.tx_code_group, bus.rd_out, bus.code_err}
        !== {10'h0FA, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL k28_5a: got %h/%b/%b want 0fa/1/0",
               bus.tx_code_group, bus.rd_out, bus.code_err);
    end
    cyc(1'b1, 1'b1, 8'hBC, 1'b1, acc);
    n_chk++;
    if ({bus.tx_code_group, bus.rd_out} !== {10'h305, 1'b0}) begin
      n_fail++;
      $display("FAIL k28_5b: got %h/%b want 305/0",
               bus.tx_code_group, bus.rd_out);
    end
  endtask

  task automatic test_alt7();
    bit acc;
    cyc(1'b1, 1'b0, 8'hF1, 1'b1, acc);
    n_chk++;
    if ({bus.tx_code_group, bus.rd_out} !== {10'h237, 1'b1}) begin
      n_fail++;
      $display("FAIL d17_7: got %h/%b want 237/1",
               bus.tx_code_group, bus.rd_out);
    end
    cyc(1'b1, 1'b0, 8'hEB, 1'b1, acc);
    n_chk++;
    if ({bus.tx_code_group, bus.rd_out} !== {10'h348, 1'b0}) begin
      n_fail++;
      $display("FAIL d11_7: got %h/%b want 348/0",
               bus.tx_code_group, bus.rd_out);
    end
  endtask

  task automatic test_stall();
    bit         acc;
    logic [9:0] hc;
    logic       hr;
    cyc(1'b1, 1'b0, 8'h10, 1'b1, acc);
    hc = bus.tx_code_group;
    hr = bus.rd_out;
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 8'h21, 1'b0, acc);
      n_chk++;
      if (acc !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_ready: got %b want 0", acc);
      end
      n_chk++;
      if ({bus.tx_code_group, bus.rd_out} !== {hc, hr}) begin
        n_fail++;
        $display("FAIL stall_hold: got %h/%b want %h/%b",
                 bus.tx_code_group, bus.rd_out, hc, hr);
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 8'h21 + 8'(i * 17), 1'b1, acc);
      n_chk++;
      if (acc !== 1'b1) begin
        n_fail++;
        $display("FAIL release_ready: got %b want 1", acc);
      end
    end
  endtask

  task automatic test_idle();
    bit         acc;
    logic [9:0] want;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, 1'b0, 8'h00, 1'b1, acc);
      want = (i % 2 == 0) ? 10'h0FA : 10'h305;
      n_chk++;
      if ({bus.tx_valid, bus.tx_code_group} !== {1'b1, want}) begin
        n_fail++;
        $display("FAIL idle_%0d: got %b/%h want 1/%h",
                 i, bus.tx_valid, bus.tx_code_group, want);
      end
    end
    cyc(1'b1, 1'b0, 8'h07, 1'b1, acc);
    nreset = 1'b0;
    bus.in_valid = 1'b1;
    bus.data_in = 8'h3A;
    @(posedge clk);
    @(negedge clk);
    n_chk++;
    if ({bus.tx_valid, bus.tx_code_group, bus.rd_out}
        !== {1'b0, 10'h0FA, 1'b0}) begin
      n_fail++;
      $display("FAIL mid_reset: got %b/%h/%b want 0/0fa/0",
               bus.tx_valid, bus.tx_code_group, bus.rd_out);
    end
    sbq.delete();
    mrd = 1'b0;
    nreset = 1'b1;
  endtask

  task automatic test_code_err();
    bit acc;
    do_reset();
    cyc(1'b1, 1'b1, 8'h00, 1'b1, acc);
    n_chk++;
    if ({bus.tx_code_group, bus.code_err} !== {10'h274, 1'b1}) begin
      n_fail++;
      $display("FAIL kerr: got %h/%b want 274/1",
               bus.tx_code_group, bus.code_err);
    end
    cyc(1'b1, 1'b0, 8'hB5, 1'b1, acc);
    n_chk++;
    if ({bus.tx_code_group, bus.code_err} !== {10'h2AA, 1'b0}) begin
      n_fail++;
      $display("FAIL kerr_clear: got %h/%b want 2aa/0",
               bus.tx_code_group, bus.code_err);
    end
  endtask

  task automatic test_all_codes();
    bit acc;
    bit prd;
    int pc;
    bit ok;
    do_reset();
    prd = bus.rd_out;
    for (int i = 0; i < 268; i++) begin
      if (i < 256) cyc(1'b1, 1'b0, 8'(i), 1'b1, acc);
      else         cyc(1'b1, 1'b1, KB[i - 256], 1'b1, acc);
      pc = $countones(bus.tx_code_group);
      ok = (pc == 5 && bus.rd_out == prd) ||
           (pc == 6 && !prd && bus.rd_out) ||
           (pc == 4 && prd && !bus.rd_out);
      n_chk++;
      if (!ok || bus.code_err !== 1'b0) begin
        n_fail++;
        $display("FAIL disparity_%0d: got %h rd %b err %b from rd %b",
                 i, bus.tx_code_group, bus.rd_out,
                 bus.code_err, prd);
      end
      prd = bus.rd_out;
    end
  endtask

  task automatic test_back_to_back();
    bit         acc, have, v, k, rdy;
    logic [7:0] d;
    have = 1'b0;
    k = 1'b0;
    d = 8'h00;
    for (int i = 0; i < 300; i++) begin
      if (!have && $urandom_range(0, 3) != 0) begin
        have = 1'b1;
        k = ($urandom_range(0, 4) == 0);
        d = (k && $urandom_range(0, 1) == 1) ?
            KB[$urandom_range(0, 11)] : 8'($urandom);
      end
      v   = have;
      rdy = ($urandom_range(0, 3) != 0);
      cyc(v, k, d, rdy, acc);
      if (acc) have = 1'b0;
    end
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 8'h00, 1'b1, acc);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    n_chk = 0;
    n_fail = 0;
    mrd = 1'b0;
    nreset = 1'b0;
    bus.in_valid = 1'b0;
    bus.K_in = 1'b0;
    bus.data_in = 8'h00;
    bus.tx_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_data();
    test_k285();
    test_alt7();
    test_stall();
    test_idle();
    test_code_err();
    test_all_codes();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
